// File: rtl/edic_pkg.sv
// Shared definitions for the fetch unit: state encoding and the default reset PC.
package edic_pkg;
   typedef enum logic [2:0] {
      S_START,
      S_ADDR_OP,
      S_READ_OP,
      S_ADDR_ARG,
      S_READ_ARG,
      S_VALID
   } fetch_state_t;

   localparam logic [7:0] EDIC_RESET_PC = 8'h00;
endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's RAM, redirect and instruction-handshake signals.
interface instr_fetch_if;
   logic [7:0] ramAddress;
   logic       ramAddressEn;
   logic       ramDataSelect;
   logic       ramOutEnable;
   logic [7:0] ramData;
   logic       jumpEn;
   logic [7:0] jumpAddr;
   logic       instrValid;
   logic       instrReady;
   logic [7:0] opcode;
   logic [7:0] operand;
   logic [7:0] pc;

   // Fetch-unit side.
   modport master (
      output ramAddress, ramAddressEn, ramDataSelect, ramOutEnable,
      output instrValid, opcode, operand, pc,
      input  ramData, jumpEn, jumpAddr, instrReady
   );

   // RAM / consumer side.
   modport slave (
      input  ramAddress, ramAddressEn, ramDataSelect, ramOutEnable,
      input  instrValid, opcode, operand, pc,
      output ramData, jumpEn, jumpAddr, instrReady
   );
endinterface

// File: rtl/instr_fetch.sv
// Two-byte instruction fetcher: addresses RAM, captures opcode and operand,
// and presents them on a valid/ready handshake with redirect support.
module instr_fetch
   import edic_pkg::*;
#(
   parameter logic [7:0] RESET_PC = EDIC_RESET_PC
) (
   input  logic       i_clk,
   input  logic       i_nReset,
   output logic [7:0] o_ramAddress,
   output logic       o_ramAddressEn,
   output logic       o_ramDataSelect,
   output logic       o_ramOutEnable,
   input  logic [7:0] i_ramData,
   input  logic       i_jumpEn,
   input  logic [7:0] i_jumpAddr,
   output logic       o_instrValid,
   input  logic       i_instrReady,
   output logic [7:0] o_opcode,
   output logic [7:0] o_operand,
   output logic [7:0] o_pc
);

   fetch_state_t r_state;
   fetch_state_t w_next;
   logic [7:0]   r_pc;
   logic [7:0]   r_opcode;
   logic [7:0]   r_operand;
   logic [7:0]   r_instrPc;
   logic         w_jump;

   // A redirect is only honoured once the unit has left its post-reset state.
   assign w_jump = i_jumpEn && (r_state != S_START);

   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) r_state <= S_START;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_START:    w_next = S_ADDR_OP;
         S_ADDR_OP:  w_next = S_READ_OP;
         S_READ_OP:  w_next = S_ADDR_ARG;
         S_ADDR_ARG: w_next = S_READ_ARG;
         S_READ_ARG: w_next = S_VALID;
         S_VALID:    if (i_instrReady) w_next = S_ADDR_OP;
         default:    w_next = S_START;
      endcase
      if (w_jump) w_next = S_ADDR_OP;
   end

   // Enables come straight from the state register so reset forces them low.
   always_comb begin
      o_ramAddressEn = (r_state == S_ADDR_OP) || (r_state == S_ADDR_ARG);
      o_ramOutEnable = (r_state == S_READ_OP) || (r_state == S_READ_ARG);
      o_instrValid   = (r_state == S_VALID);
   end

   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         r_pc      <= RESET_PC;
         r_opcode  <= 8'h00;
         r_operand <= 8'h00;
         r_instrPc <= RESET_PC;
      end else if (w_jump) begin
         r_pc <= i_jumpAddr;
      end else begin
         case (r_state)
            S_ADDR_OP: r_instrPc <= r_pc;
            S_READ_OP: begin
               r_opcode <= i_ramData;
               r_pc     <= r_pc + 8'd1;
            end
            S_READ_ARG: begin
               r_operand <= i_ramData;
               r_pc      <= r_pc + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_ramAddress    = r_pc;
   assign o_ramDataSelect = 1'b0;
   assign o_opcode        = r_opcode;
   assign o_operand       = r_operand;
   assign o_pc            = r_instrPc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table after reset, hand-written corner sequences,
// then randomized ready/redirect traffic against a transaction-level model.
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if bus();
   instr_fetch_if busw();

   logic [7:0] mem  [256];
   logic [7:0] memw [256];
   logic [7:0] areg, aregw;

   // RAM model: address register loaded on address-enable, read bus driven on out-enable.
   always @(posedge clk) if (bus.ramAddressEn)  areg  <= bus.ramAddress;
   always @(posedge clk) if (busw.ramAddressEn) aregw <= busw.ramAddress;
   assign bus.ramData  = bus.ramOutEnable  ? mem[areg]   : 8'hEE;
   assign busw.ramData = busw.ramOutEnable ? memw[aregw] : 8'hEE;

   instr_fetch u_dut (
      .i_clk(clk), .i_nReset(rst_n),
      .o_ramAddress(bus.ramAddress), .o_ramAddressEn(bus.ramAddressEn),
      .o_ramDataSelect(bus.ramDataSelect), .o_ramOutEnable(bus.ramOutEnable),
      .i_ramData(bus.ramData), .i_jumpEn(bus.jumpEn), .i_jumpAddr(bus.jumpAddr),
      .o_instrValid(bus.instrValid), .i_instrReady(bus.instrReady),
      .o_opcode(bus.opcode), .o_operand(bus.operand), .o_pc(bus.pc)
   );

   instr_fetch #(.RESET_PC(8'hFF)) u_dut_w (
      .i_clk(clk), .i_nReset(rst_n),
      .o_ramAddress(busw.ramAddress), .o_ramAddressEn(busw.ramAddressEn),
      .o_ramDataSelect(busw.ramDataSelect), .o_ramOutEnable(busw.ramOutEnable),
      .i_ramData(busw.ramData), .i_jumpEn(busw.jumpEn), .i_jumpAddr(busw.jumpAddr),
      .o_instrValid(busw.instrValid), .i_instrReady(busw.instrReady),
      .o_opcode(busw.opcode), .o_operand(busw.operand), .o_pc(busw.pc)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.jumpEn = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_aen",  bus.ramAddressEn, 0);
      chk("rst_oen",  bus.ramOutEnable, 0);
      chk("rst_vld",  bus.instrValid, 0);
      chk("rst_sel",  bus.ramDataSelect, 0);
      chk("rst_op",   bus.opcode, 8'h00);
      chk("rst_arg",  bus.operand, 8'h00);
      chk("rst_pc",   bus.pc, 8'h00);
      chk("rst_addr", bus.ramAddress, 8'h00);
      chk("rstw_pc",  busw.pc, 8'hFF);
      chk("rstw_addr", busw.ramAddress, 8'hFF);
      rst_n = 1'b1;
   endtask

   typedef struct packed {
      logic       aen;
      logic       oen;
      logic       vld;
      logic [7:0] addr;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [7:0] ep, ep1, ja;
      int         wt;
      logic       r, j;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h01};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h01};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h02};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h02};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h02};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h03};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h03};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h04};

      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'($urandom);
         memw[i] = 8'($urandom);
      end
      mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hC3; mem[8'h03] = 8'hD4;
      mem[8'h40] = 8'h5A; mem[8'h41] = 8'h6B;
      mem[8'h80] = 8'h9C; mem[8'h81] = 8'h8D;
      memw[8'hFF] = 8'h11; memw[8'h00] = 8'h22;

      bus.jumpEn = 1'b0;  bus.jumpAddr = 8'h00;  bus.instrReady = 1'b1;
      busw.jumpEn = 1'b0; busw.jumpAddr = 8'h00; busw.instrReady = 1'b1;

      // Free-running fetch with ready held high, plus the wrap-around unit.
      do_reset();
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("tbl%0d_aen", k),  bus.ramAddressEn, tbl[k].aen);
         chk($sformatf("tbl%0d_oen", k),  bus.ramOutEnable, tbl[k].oen);
         chk($sformatf("tbl%0d_vld", k),  bus.instrValid,   tbl[k].vld);
         chk($sformatf("tbl%0d_addr", k), bus.ramAddress,   tbl[k].addr);
         chk($sformatf("tbl%0d_excl", k), bus.ramAddressEn & bus.ramOutEnable, 0);
         if (k == 5) begin
            chk("free1_op", bus.opcode, 8'hA1);
            chk("free1_arg", bus.operand, 8'hB2);
            chk("free1_pc", bus.pc, 8'h00);
            chk("wrap_vld", busw.instrValid, 1);
            chk("wrap_op", busw.opcode, 8'h11);
            chk("wrap_arg", busw.operand, 8'h22);
            chk("wrap_pc", busw.pc, 8'hFF);
         end
         if (k == 10) begin
            chk("free2_op", bus.opcode, 8'hC3);
            chk("free2_arg", bus.operand, 8'hD4);
            chk("free2_pc", bus.pc, 8'h02);
            chk("wrap2_vld", busw.instrValid, 1);
            chk("wrap2_pc", busw.pc, 8'h01);
         end
         if (k < 10) tick();
      end

      // Backpressure: three cycles stalled in the valid state.
      do_reset();
      bus.instrReady = 1'b0;
      repeat (5) tick();
      for (int i = 0; i < 3; i++) begin
         chk("bp_vld", bus.instrValid, 1);
         chk("bp_aen", bus.ramAddressEn, 0);
         chk("bp_oen", bus.ramOutEnable, 0);
         chk("bp_op",  bus.opcode, 8'hA1);
         chk("bp_arg", bus.operand, 8'hB2);
         chk("bp_pc",  bus.pc, 8'h00);
         if (i < 2) tick();
      end
      bus.instrReady = 1'b1;
      tick();
      chk("bp_resume_vld", bus.instrValid, 0);
      chk("bp_resume_aen", bus.ramAddressEn, 1);
      chk("bp_resume_addr", bus.ramAddress, 8'h02);

      // Redirect while the operand is being read.
      do_reset();
      repeat (4) tick();
      chk("jra_oen", bus.ramOutEnable, 1);
      bus.jumpEn = 1'b1; bus.jumpAddr = 8'h40;
      tick();
      bus.jumpEn = 1'b0;
      chk("jra_aen", bus.ramAddressEn, 1);
      chk("jra_addr", bus.ramAddress, 8'h40);
      for (int i = 0; i < 3; i++) begin
         chk("jra_novld", bus.instrValid, 0);
         tick();
      end
      chk("jra_novld", bus.instrValid, 0);
      tick();
      chk("jra_vld", bus.instrValid, 1);
      chk("jra_op",  bus.opcode, 8'h5A);
      chk("jra_arg", bus.operand, 8'h6B);
      chk("jra_pc",  bus.pc, 8'h40);

      // Redirect coinciding with an accepted instruction.
      bus.jumpEn = 1'b1; bus.jumpAddr = 8'h80;
      tick();
      bus.jumpEn = 1'b0;
      chk("jv_vld", bus.instrValid, 0);
      chk("jv_aen", bus.ramAddressEn, 1);
      chk("jv_addr", bus.ramAddress, 8'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("jv_novld", bus.instrValid, 0);
      end
      tick();
      chk("jv_vld2", bus.instrValid, 1);
      chk("jv_op",  bus.opcode, 8'h9C);
      chk("jv_arg", bus.operand, 8'h8D);
      chk("jv_pc",  bus.pc, 8'h80);

      // Asynchronous reset during the opcode read.
      do_reset();
      repeat (2) tick();
      chk("ar_oen_before", bus.ramOutEnable, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_oen", bus.ramOutEnable, 0);
      chk("ar_aen", bus.ramAddressEn, 0);
      chk("ar_vld", bus.instrValid, 0);
      chk("ar_addr", bus.ramAddress, 8'h00);
      chk("ar_pc", bus.pc, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_restart_aen", bus.ramAddressEn, 1);
      chk("ar_restart_addr", bus.ramAddress, 8'h00);

      // Random ready/redirect traffic. Model: next instruction address and the
      // number of edges until it should be presented.
      do_reset();
      ep = 8'h00;
      wt = 5;
      for (int c = 0; c < 1500; c++) begin
         chk("rnd_vld", bus.instrValid, (wt == 0));
         chk("rnd_excl", bus.ramAddressEn & bus.ramOutEnable, 0);
         if (wt == 0 && bus.instrValid) begin
            ep1 = ep + 8'd1;
            chk("rnd_op",  bus.opcode, mem[ep]);
            chk("rnd_arg", bus.operand, mem[ep1]);
            chk("rnd_pc",  bus.pc, ep);
         end
         r  = 1'($urandom_range(0, 1));
         j  = (wt != 5) && ($urandom_range(0, 15) == 0);
         ja = 8'($urandom);
         bus.instrReady = r;
         bus.jumpEn     = j;
         bus.jumpAddr   = ja;
         tick();
         if (j) begin
            ep = ja;
            wt = 4;
         end else if (wt == 0) begin
            if (r) begin
               ep = ep + 8'd2;
               wt = 4;
            end
         end else begin
            wt--;
         end
      end
      bus.jumpEn = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
